// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control-unit <-> fetch-unit bundle. The master drives next-PC controls and the raw buttons; the slave is the fetch unit.
// The step input exists only when FETCH_SINGLE_STEP_EN is defined.
interface pc_fetch_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [2:0]        pc_ctrl;
    logic [4:0]        opcode;
    logic [ADDR_W-1:0] target_addr;
    logic [DATA_W-1:0] reg_addr;
    logic              confirm;
`ifdef FETCH_SINGLE_STEP_EN
    logic              step;
`endif
    logic [ADDR_W-1:0] pc;
    logic              in_ack;
    logic              waiting_in;
    logic              halted;
    logic              exec_en;
    logic [CNT_W-1:0]  instr_count;

    modport master (
`ifdef FETCH_SINGLE_STEP_EN
        output step,
`endif
        output pc_ctrl, output opcode, output target_addr, output reg_addr, output confirm,
        input  pc, input in_ack, input waiting_in, input halted, input exec_en, input instr_count
    );

    modport slave (
`ifdef FETCH_SINGLE_STEP_EN
        input  step,
`endif
        input  pc_ctrl, input opcode, input target_addr, input reg_addr, input confirm,
        output pc, output in_ack, output waiting_in, output halted, output exec_en, output instr_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer with input-wait stall, sticky HALT and retired-instruction counter.
// Latency: PC updates on the clock after pc_ctrl is presented; confirm rising to in_ack is 3 clocks (2-flop sync + edge).
// Backpressure: WAIT_IN holds the PC until a confirm edge; FETCH_SINGLE_STEP_EN gates RUN progress on step edges.
module pc_fetch_unit #(
    parameter int         ADDR_W  = 10,
    parameter int         DATA_W  = 32,
    parameter logic [4:0] OP_IN   = 5'd19,
    parameter logic [4:0] OP_HALT = 5'd18,
    parameter int         CNT_W   = 16
) (
    input  logic      clock,
    input  logic      reset,
    pc_fetch_if.slave fetchBus
);
    typedef enum logic [1:0] {RUN = 2'd0, WAIT_IN = 2'd1, HALT = 2'd2} state_t;

    localparam int                JR_W    = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t            stateQ, stateNext;
    logic [ADDR_W-1:0] pcQ, pcNext;
    logic [CNT_W-1:0]  countQ;
    logic              countInc;
    logic              inAckQ, inAckNext;
    logic [2:0]        confirmSync;
    logic              confirmEdge;
    logic              runAdvance;

    // [0],[1] synchronize, [2] is edge history; all reset high so a held button is not an edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) confirmSync <= 3'b111;
        else       confirmSync <= {confirmSync[1:0], fetchBus.confirm};
    end
    assign confirmEdge = confirmSync[1] & ~confirmSync[2];

`ifdef FETCH_SINGLE_STEP_EN
    logic [2:0] stepSync;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stepSync <= 3'b111;
        else       stepSync <= {stepSync[1:0], fetchBus.step};
    end
    assign runAdvance = stepSync[1] & ~stepSync[2];
`else
    assign runAdvance = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ <= RUN;
            pcQ    <= '0;
            inAckQ <= 1'b0;
            countQ <= '0;
        end else begin
            stateQ <= stateNext;
            pcQ    <= pcNext;
            inAckQ <= inAckNext;
            if (countInc && (countQ != CNT_MAX))
                countQ <= countQ + CNT_ONE;
        end
    end

    always_comb begin
        stateNext = stateQ;
        pcNext    = pcQ;
        inAckNext = 1'b0;
        countInc  = 1'b0;
        case (stateQ)
            RUN: begin
                if (runAdvance) begin
                    countInc = 1'b1;
                    case (fetchBus.pc_ctrl)
                        3'b001, 3'b010: pcNext = fetchBus.target_addr;
                        3'b011:         pcNext = ADDR_W'(fetchBus.reg_addr[JR_W-1:0]);
                        3'b111: begin
                            // Entering a stall does not retire the stalling instruction
                            if (fetchBus.opcode == OP_HALT) begin
                                stateNext = HALT;
                                countInc  = 1'b0;
                            end else if (fetchBus.opcode == OP_IN) begin
                                stateNext = WAIT_IN;
                                countInc  = 1'b0;
                            end
                        end
                        default:        pcNext = pcQ + PC_ONE;
                    endcase
                end
            end
            WAIT_IN: begin
                if (confirmEdge) begin
                    stateNext = RUN;
                    inAckNext = 1'b1;
                end
            end
            HALT:    stateNext = HALT;
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        fetchBus.exec_en    = (stateQ == RUN) && runAdvance;
        fetchBus.waiting_in = (stateQ == WAIT_IN);
        fetchBus.halted     = (stateQ == HALT);
    end

    assign fetchBus.pc          = pcQ;
    assign fetchBus.in_ack      = inAckQ;
    assign fetchBus.instr_count = countQ;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a behavioural model of the fetch sequencer.
module tb_pc_fetch_unit;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 8;
    localparam longint PC_MOD  = 64'd1 << ADDR_W;
    localparam longint CNT_SAT = (64'd1 << CNT_W) - 1;
    localparam int ST_RUN  = 0;
    localparam int ST_WAIT = 1;
    localparam int ST_HALT = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pc_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) fetchBus ();

    pc_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_IN(5'd19), .OP_HALT(5'd18), .CNT_W(CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .fetchBus(fetchBus)
    );

    always #5 clock = ~clock;

    int     checks = 0;
    int     fails  = 0;
    int     ackCount = 0;
    string  phase = "init";
    longint mPc, mCount, haltPc;
    int     mMode, mAck;
    bit [2:0] cSeen;   // confirm as sampled at the last three edges, newest in [0]
    bit [2:0] sSeen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s [%s] got=0x%0h expected=0x%0h", tag, phase, got, exp);
        end
    endtask

    // Spec-vector constants only hold when every RUN cycle advances
    task automatic check_directed(input string tag, input logic [63:0] got, input logic [63:0] exp);
`ifndef FETCH_SINGLE_STEP_EN
        check_val(tag, got, exp);
`endif
    endtask

    function automatic void model_reset();
        mPc = 0; mCount = 0; mMode = ST_RUN; mAck = 0;
        cSeen = 3'b111; sSeen = 3'b111;
    endfunction

    function automatic void model_edge();
        bit     risen;
        bit     adv;
        int     ctrl;
        int     op;
        longint r;
        if (reset) return;
        risen = cSeen[1] && !cSeen[2];
        adv   = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
        adv   = sSeen[1] && !sSeen[2];
        sSeen = {sSeen[1:0], fetchBus.step};
`endif
        cSeen = {cSeen[1:0], fetchBus.confirm};
        ctrl  = int'(fetchBus.pc_ctrl);
        op    = int'(fetchBus.opcode);
        mAck  = 0;
        if (mMode == ST_RUN && adv) begin
            if (ctrl == 7 && op == 18)      mMode = ST_HALT;
            else if (ctrl == 7 && op == 19) mMode = ST_WAIT;
            else begin
                if (mCount < CNT_SAT) mCount++;
                r = fetchBus.reg_addr;
                if (ctrl == 1 || ctrl == 2) mPc = fetchBus.target_addr;
                else if (ctrl == 3)         mPc = r % PC_MOD;
                else if (ctrl != 7)         mPc = (mPc + 1) % PC_MOD;
            end
        end else if (mMode == ST_WAIT && risen) begin
            mMode = ST_RUN;
            mAck  = 1;
        end
    endfunction

    task automatic compare_all();
        check_val("pc",          fetchBus.pc,          mPc);
        check_val("in_ack",      fetchBus.in_ack,      mAck);
        check_val("waiting_in",  fetchBus.waiting_in,  mMode == ST_WAIT);
        check_val("halted",      fetchBus.halted,      mMode == ST_HALT);
        check_val("instr_count", fetchBus.instr_count, mCount);
`ifndef FETCH_SINGLE_STEP_EN
        check_val("exec_en",     fetchBus.exec_en,     mMode == ST_RUN);
`endif
    endtask

    task automatic tick();
`ifdef FETCH_SINGLE_STEP_EN
        fetchBus.step = 1'($urandom_range(0, 1));
`endif
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
        if (fetchBus.in_ack === 1'b1) ackCount++;
    endtask

    // Called 1 time unit after a rising edge; reset lands mid-cycle
    task automatic apply_reset(input int holdCycles);
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        for (int i = 0; i < holdCycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic set_ctrl(input logic [2:0] c, input logic [4:0] op);
        fetchBus.pc_ctrl = c;
        fetchBus.opcode  = op;
    endtask

    initial begin
        int haltTicks;
        int r;
        fetchBus.pc_ctrl = 3'b000; fetchBus.opcode = 5'd0;
        fetchBus.target_addr = '0; fetchBus.reg_addr = '0; fetchBus.confirm = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        fetchBus.step = 1'b0;
`endif
        phase = "reset";
        apply_reset(2);
        check_directed("rstPc", fetchBus.pc, 0);

        phase = "seq";
        for (int i = 0; i < 5; i++) tick();
        check_directed("seqPc", fetchBus.pc, 5);
        check_directed("seqCount", fetchBus.instr_count, 5);
        check_directed("seqExec", fetchBus.exec_en, 1);

        phase = "jumps";
        fetchBus.pc_ctrl = 3'b001; fetchBus.target_addr = 10'h3FF; tick();
        check_directed("jTop", fetchBus.pc, 10'h3FF);
        fetchBus.pc_ctrl = 3'b000; tick();
        check_directed("wrap", fetchBus.pc, 0);
        fetchBus.pc_ctrl = 3'b001; fetchBus.target_addr = 10'h155; tick();
        check_directed("jImm", fetchBus.pc, 10'h155);
        fetchBus.pc_ctrl = 3'b011; fetchBus.reg_addr = 32'hFFFF_F0A0; tick();
        check_directed("jr", fetchBus.pc, 10'h0A0);

        phase = "wait20";
        set_ctrl(3'b111, 5'd19); tick();
        check_directed("waitEnter", fetchBus.waiting_in, 1);
        for (int i = 0; i < 20; i++) begin
            fetchBus.pc_ctrl = 3'($urandom_range(0, 7));
            fetchBus.target_addr = ADDR_W'($urandom);
            tick();
            check_directed("waitHold", fetchBus.pc, 10'h0A0);
        end
        set_ctrl(3'b000, 5'd0);
        fetchBus.confirm = 1'b1; tick();
        fetchBus.confirm = 1'b0; tick();
        check_directed("ackEarly", fetchBus.in_ack, 0);
        tick();
        check_directed("ackLatency", fetchBus.in_ack, 1);
        check_directed("ackLeaveWait", fetchBus.waiting_in, 0);
        tick();
        check_directed("ackPulse", fetchBus.in_ack, 0);
        check_directed("pcAfterIn", fetchBus.pc, 10'h0A1);

        phase = "hold50";
        set_ctrl(3'b111, 5'd19); tick();
        set_ctrl(3'b000, 5'd0);
        ackCount = 0;
        fetchBus.confirm = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        fetchBus.confirm = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("heldOneAck", ackCount, 1);
        ackCount = 0;
        fetchBus.confirm = 1'b1; tick();
        fetchBus.confirm = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_val("runNoAck", ackCount, 0);

        phase = "halt";
        set_ctrl(3'b111, 5'd18); tick();
        check_val("haltFlag", fetchBus.halted, 1);
        check_val("haltExec", fetchBus.exec_en, 0);
        haltPc = mPc;
        ackCount = 0;
        for (int i = 0; i < 100; i++) begin
            fetchBus.pc_ctrl = 3'($urandom_range(0, 7));
            fetchBus.opcode  = 5'($urandom_range(0, 31));
            fetchBus.confirm = 1'($urandom_range(0, 1));
            tick();
        end
        check_val("haltFrozen", fetchBus.pc, haltPc);
        check_val("haltNoAck", ackCount, 0);
        apply_reset(2);
        check_val("haltCleared", fetchBus.halted, 0);

        phase = "rstInWait";
        set_ctrl(3'b111, 5'd19); fetchBus.confirm = 1'b0; tick();
        set_ctrl(3'b000, 5'd0);
        fetchBus.confirm = 1'b1; tick(); tick();
        apply_reset(1);
        check_val("rstWaitPc", fetchBus.pc, 0);
        check_val("rstWaitState", fetchBus.waiting_in, 0);
        ackCount = 0;
        for (int i = 0; i < 10; i++) tick();
        check_val("rstWaitNoAck", ackCount, 0);
        fetchBus.confirm = 1'b0;

        phase = "saturate";
        apply_reset(1);
        for (int i = 0; i < 300; i++) tick();
        check_directed("satCount", fetchBus.instr_count, CNT_SAT);

        phase = "random";
        haltTicks = 0;
        for (int i = 0; i < 800; i++) begin
            fetchBus.pc_ctrl = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            if (r == 0)     fetchBus.opcode = 5'd18;
            else if (r < 5) fetchBus.opcode = 5'd19;
            else            fetchBus.opcode = 5'($urandom_range(0, 17));
            fetchBus.target_addr = ADDR_W'($urandom);
            fetchBus.reg_addr    = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) fetchBus.confirm = ~fetchBus.confirm;
            tick();
            if (mMode == ST_HALT) haltTicks++;
            else                  haltTicks = 0;
            if (haltTicks > 8) begin
                apply_reset(1);
                haltTicks = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
